// File: rtl/lcd_refresh_scheduler_pkg.sv
// Package lcd_sched_pkg: shared widths, frame-buffer depth, refresh FSM states,
// display line base addresses and a saturating counter helper for the LCD
// refresh scheduler.
// Optional feature macro used by the scheduler: LCD_SCHED_RR_ARB_EN.
package lcd_sched_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int FB_DEPTH = 128;
  localparam int CNT_W    = 16;

  // Frame buffer addresses are {line[1:0], col[4:0]}; these are the column-0
  // addresses of the four display lines.
  localparam logic [ADDR_W-1:0] L1_BASE = 7'd0;
  localparam logic [ADDR_W-1:0] L2_BASE = 7'd32;
  localparam logic [ADDR_W-1:0] L3_BASE = 7'd64;
  localparam logic [ADDR_W-1:0] L4_BASE = 7'd96;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    WAIT_FALL,
    HOLDOFF
  } state_t;

  // Counters stop at all-ones so a stuck driver can never wrap them back
  // into a range that looks like a fresh wait.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lcd_refresh_scheduler_if.sv
// Interface lcd_refresh_scheduler_if: bundles the two write requesters and
// the HD44780 driver port of the refresh scheduler.
//  req0_*/req1_* : valid/addr/data from requester, ready back to it
//  lcd_busy      : driver busy, lcd_addr: driver read address
//  lcd_data      : registered read data, lcd_trg: refresh trigger pulse
// Modports: master = requesters + driver side, slave = scheduler.
interface lcd_refresh_scheduler_if
  import lcd_sched_pkg::*;
();

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              lcd_busy;
  logic [ADDR_W-1:0] lcd_addr;
  logic [DATA_W-1:0] lcd_data;
  logic              lcd_trg;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output lcd_busy, lcd_addr,
    input  req0_ready, req1_ready, lcd_data, lcd_trg
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  lcd_busy, lcd_addr,
    output req0_ready, req1_ready, lcd_data, lcd_trg
  );

endinterface

// File: rtl/lcd_refresh_scheduler_ram.sv
// Module lcd_fb_ram: 1-write 1-read character frame buffer, DEPTH x DW.
//  clk               : clock
//  wr_en/wr_addr/wr_data : write port, lands at the clock edge
//  rd_addr/rd_data   : registered read, read-before-write on address collision
// The storage array and read register are deliberately not reset so the
// displayed text survives a scheduler reset.
module lcd_fb_ram
  import lcd_sched_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // The read sees the array before this edge's write, giving old data on a
  // same-address collision.
  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Write and read registers share the edge; neither is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// Module lcd_refresh_scheduler: owns the 128x8 frame buffer for the HD44780
// driver, arbitrates two writers, serves the driver read port and schedules
// refresh triggers with a hold-off between refreshes.
//  clk, rst  : clock, asynchronous active-high reset
//  bus       : requesters + driver port (lcd_refresh_scheduler_if.slave)
//  flush     : request one refresh even when clean (held until serviced)
//  dirty     : buffer written since the last trigger
//  tmo_err   : sticky, driver never went busy after a trigger
// Macro LCD_SCHED_RR_ARB_EN selects round-robin arbitration; otherwise
// req0 has fixed priority over req1. HOLDOFF_CYC and RISE_TMO must be >= 1.
module lcd_refresh_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int HOLDOFF_CYC = 2500,
  parameter int RISE_TMO    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  lcd_refresh_scheduler_if.slave bus,
  input  logic                   flush,
  output logic                   dirty,
  output logic                   tmo_err
);

  logic              gnt0, gnt1, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] ram_rd_data;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dirty_q, dirty_d;
  logic              flush_pend_q, flush_pend_d;
  logic              tmo_err_q, tmo_err_d;
  logic              lcd_trg_q, lcd_trg_d;
  logic              rd_valid_q, rd_valid_d;

`ifdef LCD_SCHED_RR_ARB_EN
  logic prio1_q, prio1_d;

  // Round-robin: on contention the pointer picks the winner; any grant hands
  // priority to the other requester for the next contention.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    prio1_d = prio1_q;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = !prio1_q;
        gnt1 = prio1_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
    if (gnt0) begin
      prio1_d = 1'b1;
    end else if (gnt1) begin
      prio1_d = 1'b0;
    end
  end

  // Priority pointer starts at req0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio1_q <= 1'b0;
    end else begin
      prio1_q <= prio1_d;
    end
  end
`else
  // Fixed priority: req0 always wins; req1 only writes when req0 is quiet.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = bus.req0_valid;
      gnt1 = bus.req1_valid && !bus.req0_valid;
    end
  end
`endif

  // The granted requester drives the single RAM write port.
  always_comb begin
    wr_en   = gnt0 | gnt1;
    wr_addr = gnt0 ? bus.req0_addr : bus.req1_addr;
    wr_data = gnt0 ? bus.req0_data : bus.req1_data;
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  lcd_fb_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (bus.lcd_addr),
    .rd_data (ram_rd_data)
  );

  // Refresh FSM. The counter holds cycles since the trigger in WAIT_RISE and
  // hold-off cycles in HOLDOFF. A write accepted in any state (including the
  // trigger cycle) leaves dirty set so a torn frame gets a follow-up refresh.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dirty_d      = dirty_q;
    flush_pend_d = flush_pend_q | flush;
    tmo_err_d    = tmo_err_q;
    lcd_trg_d    = 1'b0;
    rd_valid_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if ((dirty_q || flush_pend_q) && !bus.lcd_busy) begin
          state_d   = TRIG;
          lcd_trg_d = 1'b1;
        end
      end
      TRIG: begin
        dirty_d      = 1'b0;
        flush_pend_d = flush;
        cnt_d        = CNT_W'(1);
        state_d      = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (bus.lcd_busy) begin
          state_d = WAIT_FALL;
        end else if (cnt_q >= CNT_W'(RISE_TMO - 1)) begin
          tmo_err_d = 1'b1;
          dirty_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      WAIT_FALL: begin
        if (!bus.lcd_busy) begin
          cnt_d   = '0;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt_q >= CNT_W'(HOLDOFF_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (wr_en) begin
      dirty_d = 1'b1;
    end
  end

  // Control state register; reset abandons any refresh in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dirty_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      tmo_err_q    <= 1'b0;
      lcd_trg_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dirty_q      <= dirty_d;
      flush_pend_q <= flush_pend_d;
      tmo_err_q    <= tmo_err_d;
      lcd_trg_q    <= lcd_trg_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // The RAM read register is unreset, so read data is masked to zero until
  // the first read after reset has been captured.
  assign bus.lcd_data = rd_valid_q ? ram_rd_data : '0;
  assign bus.lcd_trg  = lcd_trg_q;
  assign dirty        = dirty_q;
  assign tmo_err      = tmo_err_q;

endmodule
